// File: rtl/tinyalu_pkg.sv
// Shared definitions for the TinyALU request arbiter: operation encodings,
// FSM states, datapath widths and the default watchdog limit.
package tinyalu_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 31;
  localparam int OP_W            = 3;
  localparam int DATA_W          = 9;
  localparam int RESULT_W        = 18;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    RECOVER
  } arb_state_t;

  // Only these encodings are forwarded to the ALU; everything else is answered locally.
  function automatic logic is_alu_op(input operation_t op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_arbiter_if.sv
// Requester and ALU signal bundle for the arbiter; master is the arbiter side,
// slave is the environment (requesters plus ALU).
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = tinyalu_pkg::NUM_REQ_DEFAULT
) ();
  import tinyalu_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        ack;
  logic [RESULT_W-1:0]       rsp_result;
  logic                      rsp_err;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [OP_W-1:0]           alu_op;
  logic                      alu_start;
  logic                      alu_done;
  logic [RESULT_W-1:0]       alu_result;
  logic                      alu_rst_n;

  modport master (
    input  req, req_op, req_a, req_b, alu_done, alu_result,
    output ack, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_rst_n
  );

  modport slave (
    output req, req_op, req_a, req_b, alu_done, alu_result,
    input  ack, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_rst_n
  );

endinterface

// File: rtl/tinyalu_arbiter_rr_picker.sv
// Round-robin winner selection: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the closest requester to ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one TinyALU among NUM_REQ requesters: round-robin grant, one transaction
// in flight, local answers for no_op/illegal ops, and a watchdog that resets a hung ALU.
module tinyalu_arbiter #(
  parameter int NUM_REQ = tinyalu_pkg::NUM_REQ_DEFAULT,
  parameter int TIMEOUT = tinyalu_pkg::TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  tinyalu_arbiter_if.master bus
);
  import tinyalu_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  operation_t          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                err_q, err_d;
  logic                alive_q;

  logic [IDX_W-1:0]    win_idx;
  logic                win_valid;
  operation_t          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [NUM_REQ-1:0]  ack_vec;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    sel_op = no_op;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_op = operation_t'(bus.req_op[OP_W*i +: OP_W]);
        sel_a  = bus.req_a[DATA_W*i +: DATA_W];
        sel_b  = bus.req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          ptr_d   = win_idx + IDX_W'(1);
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (is_alu_op(op_q)) begin
          state_d = WAIT;
        end else begin
          result_d = '0;
          err_d    = (op_q != no_op);
          state_d  = RESP;
        end
      end
      WAIT: begin
        if (bus.alu_done) begin
          result_d = bus.alu_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // ALU reset is held for two cycles, counted on the shared counter.
      RECOVER: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      op_q     <= no_op;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      alive_q  <= 1'b1;
    end
  end

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_vec[i] = (state_q == RESP) && (grant_q == IDX_W'(i));
    end
  end

  assign bus.ack        = ack_vec;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_start  = ((state_q == ISSUE) && is_alu_op(op_q)) || (state_q == WAIT);
  assign bus.alu_rst_n  = alive_q && (state_q != RECOVER);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter: vector table of single transactions plus
// round-robin, spurious-done, protocol-violation and mid-transaction reset sequences.
module tb_tinyalu_arbiter;

  logic clk;
  logic reset_n;

  tinyalu_arbiter_if #(.NUM_REQ(4)) bus ();

  tinyalu_arbiter #(.NUM_REQ(4), .TIMEOUT(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [2:0] op;
    logic [8:0] a;
    logic [8:0] b;
    int         lat;
    logic [3:0] ack;
    logic [17:0] res;
    logic       err;
    int         cycles;
    int         starts;
    int         rst_low;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   alu_lat  = 0;
  int   alu_cnt  = 0;
  bit   spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] a, output bit got);
    got = 1'b0;
    a   = '0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      if (bus.ack != 4'b0) begin
        got = 1'b1;
        a   = bus.ack;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [17:0] alu_model(input logic [2:0] op, input logic [8:0] a, input logic [8:0] b);
    case (op)
      3'b001:  return {9'b0, a} + {9'b0, b};
      3'b010:  return {9'b0, a & b};
      3'b011:  return {9'b0, a ^ b};
      3'b100:  return a * b;
      default: return 18'h0;
    endcase
  endfunction

  // Behavioural ALU: done arrives alu_lat cycles after the first cycle start is seen.
  initial begin
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(posedge clk); #1;
      bus.alu_done = 1'b0;
      if (spurious) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = 18'h2AAAA;
      end else if (bus.alu_start && bus.alu_rst_n && alu_lat > 0) begin
        alu_cnt++;
        if (alu_cnt == alu_lat + 1) begin
          bus.alu_done   = 1'b1;
          bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
          alu_cnt        = 0;
        end
      end else begin
        alu_cnt = 0;
      end
    end
  end

  task automatic run_vec(input int n, input vec_t v);
    int cycles, starts, rst_low;
    logic [3:0]  a_seen;
    logic [17:0] res;
    logic        err;
    bit          got;
    alu_lat = v.lat;
    bus.req_op[3*v.who +: 3] = v.op;
    bus.req_a[9*v.who +: 9]  = v.a;
    bus.req_b[9*v.who +: 9]  = v.b;
    bus.req[v.who]           = 1'b1;
    cycles = 1; starts = 0; rst_low = 0; got = 1'b0;
    a_seen = '0; res = '0; err = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.alu_start) starts++;
      if (!bus.alu_rst_n) rst_low++;
      if (bus.ack != 4'b0) begin
        got    = 1'b1;
        a_seen = bus.ack;
        res    = bus.rsp_result;
        err    = bus.rsp_err;
      end
    end
    bus.req = '0;
    if (!got) $display("FAIL vec%0d no ack: got 0 expected %0h", n, v.ack);
    check($sformatf("vec%0d ack", n), 32'(a_seen), 32'(v.ack));
    check($sformatf("vec%0d result", n), 32'(res), 32'(v.res));
    check($sformatf("vec%0d err", n), 32'(err), 32'(v.err));
    check($sformatf("vec%0d latency", n), 32'(cycles), 32'(v.cycles));
    check($sformatf("vec%0d start_cycles", n), 32'(starts), 32'(v.starts));
    check($sformatf("vec%0d alu_rst_low", n), 32'(rst_low), 32'(v.rst_low));
    @(posedge clk); #1;
    check($sformatf("vec%0d ack_pulse", n), 32'(bus.ack), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] rr_exp [5];
    bit got;
    int bad;

    //              who op     a       b       lat ack    result     err cyc st rl
    vecs[0] = '{0, 3'b001, 9'd100, 9'd27,  1, 4'b0001, 18'd127,   1'b0, 4,  2, 0};
    vecs[1] = '{2, 3'b100, 9'h1FF, 9'h1FF, 3, 4'b0100, 18'h3FC01, 1'b0, 6,  4, 0};
    vecs[2] = '{1, 3'b111, 9'd3,   9'd4,   0, 4'b0010, 18'd0,     1'b1, 3,  0, 0};
    vecs[3] = '{3, 3'b000, 9'd5,   9'd6,   0, 4'b1000, 18'd0,     1'b0, 3,  0, 0};
    vecs[4] = '{0, 3'b010, 9'h0F0, 9'h1CC, 2, 4'b0001, 18'h000C0, 1'b0, 5,  3, 0};
    vecs[5] = '{1, 3'b011, 9'h155, 9'h0FF, 1, 4'b0010, 18'h001AA, 1'b0, 4,  2, 0};
    vecs[6] = '{2, 3'b110, 9'd9,   9'd9,   0, 4'b0100, 18'd0,     1'b1, 3,  0, 0};
    vecs[7] = '{3, 3'b001, 9'h1FF, 9'h1FF, 1, 4'b1000, 18'h003FE, 1'b0, 4,  2, 0};
    vecs[8] = '{0, 3'b011, 9'd12,  9'd34,  0, 4'b0001, 18'd0,     1'b1, 36, 32, 2};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_n = 1'b0;
    bus.req = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst alu_start", 32'(bus.alu_start), 32'd0);
    check("rst alu_rst_n", 32'(bus.alu_rst_n), 32'd0);
    check("rst alu_a", 32'(bus.alu_a), 32'd0);
    check("rst alu_op", 32'(bus.alu_op), 32'd0);
    check("rst rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("alu_rst_n release", 32'(bus.alu_rst_n), 32'd1);

    // Round-robin with all four requesting no_op
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(10, a, got);
      check($sformatf("rr ack%0d", k), 32'(a), 32'(rr_exp[k]));
    end
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Spurious alu_done while idle must not produce anything
    spurious = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack != 4'b0 || bus.alu_start) bad++;
    end
    spurious = 1'b0;
    @(posedge clk); #1;
    if (bus.ack != 4'b0 || bus.alu_start) bad++;
    check("spurious_done quiet", 32'(bad), 32'd0);

    // Requester drops req early; transaction still completes
    alu_lat = 1;
    bus.req_op[5:3] = 3'b001; bus.req_a[17:9] = 9'd3; bus.req_b[17:9] = 9'd4;
    bus.req[1] = 1'b1;
    @(posedge clk); #1;
    bus.req = '0;
    wait_ack(10, a, got);
    check("early_drop ack", 32'(a), 32'b0010);
    check("early_drop result", 32'(bus.rsp_result), 32'd7);
    @(posedge clk); #1;

    // Reset while waiting on the ALU
    alu_lat = 0;
    bus.req_op[2:0] = 3'b001; bus.req_a[8:0] = 9'd1; bus.req_b[8:0] = 9'd2;
    bus.req[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset alu_start", 32'(bus.alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset alu_start", 32'(bus.alu_start), 32'd0);
    check("mid_reset alu_rst_n", 32'(bus.alu_rst_n), 32'd0);
    bus.req = '0;
    bad = 0;
    @(posedge clk); #1;
    if (bus.ack != 4'b0) bad++;
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.ack != 4'b0 || bus.alu_start) bad++;
    end
    check("post_reset no_ack", 32'(bad), 32'd0);
    check("post_reset alu_rst_n", 32'(bus.alu_rst_n), 32'd1);
    bus.req_op = '0;
    bus.req = 4'hF;
    wait_ack(10, a, got);
    check("post_reset rr_ptr", 32'(a), 32'b0001);
    bus.req = '0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tinyalu_arbiter.md
TINYALU_ARBITER -- requirements
Module: tinyalu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (fixed at 4 for this release).
REQ-002 Parameter TIMEOUT, default 31, maximum WAIT cycles before abort.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 req  in  4  per-requester request, held high until matching ack.
REQ-006 req_op  in  12  3-bit op per requester, slice i = [3i+2:3i], stable while req[i]=1.
REQ-007 req_a / req_b  in  36 each  9-bit operands per requester, slice i = [9i+8:9i], stable while req[i]=1.
REQ-008 ack  out  4  one-cycle completion pulse per requester.
REQ-009 rsp_result  out  18  result for the acked requester, valid only while ack is non-zero.
REQ-010 rsp_err  out  1  error flag, valid only while ack is non-zero.
REQ-011 alu_a / alu_b  out  9 each  operands to the ALU.
REQ-012 alu_op  out  3  op to the ALU.
REQ-013 alu_start  out  1  ALU start.
REQ-014 alu_done  in  1  ALU done pulse.
REQ-015 alu_result  in  18  ALU result, valid when alu_done=1.
REQ-016 alu_rst_n  out  1  active-low reset to the ALU.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, RECOVER.
REQ-018 IDLE: if any req is high, the round-robin winner SHALL be granted, its op/a/b latched, and the FSM SHALL go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin: search starts at pointer rr_ptr; after a grant to i, rr_ptr = (i+1) mod 4; rr_ptr resets to 0.
REQ-020 ISSUE, legal op (add 001, and 010, xor 011, mul 100): alu_a/alu_b/alu_op SHALL be driven from the latches, alu_start=1, next state WAIT.
REQ-021 ISSUE, no_op (000): no ALU start; rsp_result=0, rsp_err=0; next state RESP.
REQ-022 ISSUE, illegal op (101, 110, 111 incl. rst_op): no ALU start; rsp_result=0, rsp_err=1; next state RESP.
REQ-023 WAIT: alu_start SHALL stay 1 and operands stable until alu_done is sampled 1; then alu_start=0, alu_result captured, rsp_err=0, next state RESP.
REQ-024 WAIT counter SHALL count sampled cycles; if it reaches TIMEOUT without alu_done, alu_start=0, rsp_err=1, rsp_result=0, next state RECOVER.
REQ-025 RECOVER: alu_rst_n SHALL be held low for exactly 2 cycles, then go to RESP.
REQ-026 RESP: ack[granted]=1 for exactly one cycle with rsp_result/rsp_err; next state IDLE.
REQ-027 A requester's req deasserted before its ack is a protocol violation; the transaction SHALL complete regardless.
REQ-028 Latency for a legal op = 3 + ALU cycles from req to ack; no_op/illegal = 3 cycles (IDLE, ISSUE, RESP).
REQ-029 alu_done outside WAIT SHALL be ignored.
REQ-030 At most one transaction SHALL be in flight; ack SHALL be one-hot or zero.

Reset
REQ-031 Reset SHALL force state IDLE, rr_ptr=0, counter=0, ack=0, rsp_result=0, rsp_err=0, alu_start=0, alu_a=0, alu_b=0, alu_op=000, alu_rst_n=0.
REQ-032 alu_rst_n SHALL go to 1 on the first clk after reset_n deasserts, except in RECOVER.
REQ-033 Reset mid-transaction SHALL drop it silently, with no ack.

Structure
REQ-034 operation_t, op encodings and the TIMEOUT default SHALL live in tinyalu_pkg.
REQ-035 Round-robin winner selection SHALL be a sub-module rr_picker (4-bit req, 2-bit ptr -> 2-bit index, valid).

Verification
REQ-036 req=0001, add, a=9'd100, b=9'd27, ALU done after 1 cycle -> ack=0001, rsp_result=127, rsp_err=0.
REQ-037 req=1111 held, all no_op -> acks in order 0001, 0010, 0100, 1000, then 0001 again.
REQ-038 req[2], mul, a=9'h1FF, b=9'h1FF -> alu_start held until done; rsp_result=18'h3FC01.
REQ-039 req[1], op=111 -> no alu_start, ack=0010 with rsp_err=1 three cycles after req.
REQ-040 req[0], xor, alu_done tied 0 -> after 31 WAIT cycles alu_rst_n low 2 cycles, then ack=0001, rsp_err=1, rsp_result=0.
REQ-041 reset_n low during WAIT -> no ack, alu_start=0 immediately, FSM in IDLE.
